// File: rtl/spi_arbiter_pkg.sv
// spi_arbiter_pkg: shared types and default constants for the SPI arbiter.
//   arb_state_t      - transaction FSM states
//   ARB_DATA_W       - default SPI word width
//   ARB_TIMEOUT_CYC  - default watchdog limit (used with SPI_ARBITER_TIMEOUT_EN)
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int ARB_DATA_W      = 8;
  localparam int ARB_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i  - request vector
//   last_i - index of the most recently served requester
//   oh_o   - one-hot winner (first set bit searching upward from last_i+1)
//   idx_o  - binary index of the winner
//   vld_o  - any request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] oh_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester once, ending at last_i itself,
  // so a lone requester is re-granted.
  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o      = 1'b1;
        idx_o      = cand;
        oh_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter serialising whole transactions from
// NUM_REQ requesters onto one SPI master engine.
//   clock, reset        - clock, async active-high reset
//   req, req_data       - per-requester request level and TX word
//   gnt, done           - one-hot grant (START..DONE) and completion pulse
//   rsp_data, err       - received word (held), timeout error pulse
//   m_start, m_tx_data  - start pulse and TX word to the SPI master
//   m_busy, m_done,
//   m_rx_data           - SPI master status, completion pulse, RX word
// Optional watchdog: define SPI_ARBITER_TIMEOUT_EN to abort transactions
// stuck in WAIT for TIMEOUT_CYC cycles (rsp_data forced to all ones, err pulses).
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      err,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_tx_data,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_rx_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t                     state_q;
  logic [IDX_W-1:0]               idx_q, last_q;
  logic [NUM_REQ-1:0]             gnt_q, done_q;
  logic                           m_start_q;
  logic [DATA_W-1:0]              tx_q, rsp_q;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_words;
  logic [NUM_REQ-1:0]             pick_oh;
  logic [IDX_W-1:0]               pick_idx;
  logic                           pick_vld;

  // m_busy is status only; completion is taken solely from m_done.
  logic unused_busy;
  assign unused_busy = m_busy;

  assign req_words = req_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .oh_o   (pick_oh),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      m_start_q <= 1'b0;
      tx_q      <= '0;
      rsp_q     <= '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; set for one cycle by the transitions below.
      m_start_q <= 1'b0;
      done_q    <= '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            idx_q     <= pick_idx;
            gnt_q     <= pick_oh;
            tx_q      <= req_words[pick_idx];
            m_start_q <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
`ifdef SPI_ARBITER_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            rsp_q         <= m_rx_data;
            done_q[idx_q] <= 1'b1;
            state_q       <= DONE;
          end
`ifdef SPI_ARBITER_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_q         <= '1;
            err_q         <= 1'b1;
            done_q[idx_q] <= 1'b1;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          // done was raised on entry; this cycle is the mandatory gap before
          // the next arbitration.
          last_q  <= idx_q;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_data  = rsp_q;
  assign m_start   = m_start_q;
  assign m_tx_data = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, done;
  logic [DW-1:0] rsp_data, m_tx_data, m_rx_data;
  logic          err, m_start, m_busy, m_done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int last_m;           // model: index of most recently served requester
  logic [DW-1:0] rsp_m; // model: last delivered response

  spi_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .rsp_data  (rsp_data),
    .err       (err),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rx_data (m_rx_data)
  );

  always #5 clock = ~clock;

  // Round-robin reference: scan the requesters in circular order after last.
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Starts in an IDLE cycle; r is sampled at the coming edge, r_mid is applied
  // during the transaction. Returns the observed grant.
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] r_mid,
                         input logic [DW-1:0] rx, input int lat,
                         output logic [N-1:0] obs_gnt);
    int            e;
    logic [N-1:0]  eg;
    logic [DW-1:0] etx;
    e   = model_pick(r, last_m);
    eg  = N'(1) << e;
    etx = req_data[e*DW +: DW];
    req = r;
    tick();
    obs_gnt = gnt;
    tot_cnt++; if (gnt !== eg) $display("FAIL start_gnt got %b want %b", gnt, eg); else pass_cnt++;
    tot_cnt++; if (m_start !== 1'b1) $display("FAIL start_pulse got %b want 1", m_start); else pass_cnt++;
    tot_cnt++; if (m_tx_data !== etx) $display("FAIL start_tx got %h want %h", m_tx_data, etx); else pass_cnt++;
    req = r_mid;
    tick();
    tot_cnt++; if (m_start !== 1'b0) $display("FAIL start_once got %b want 0", m_start); else pass_cnt++;
    repeat (lat - 1) tick();
    m_done = 1'b1; m_rx_data = rx;
    tick();
    m_done = 1'b0; m_rx_data = DW'($urandom);
    rsp_m = rx;
    tot_cnt++; if (done !== eg) $display("FAIL done_pulse got %b want %b", done, eg); else pass_cnt++;
    tot_cnt++; if (rsp_data !== rx) $display("FAIL rsp_data got %h want %h", rsp_data, rx); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL err_clear got %b want 0", err); else pass_cnt++;
    tot_cnt++; if (gnt !== eg || m_tx_data !== etx) $display("FAIL done_hold gnt %b tx %h want %b %h", gnt, m_tx_data, eg, etx); else pass_cnt++;
    tick();
    tot_cnt++; if (gnt !== '0 || done !== '0) $display("FAIL idle_clear gnt %b done %b want 0 0", gnt, done); else pass_cnt++;
    tot_cnt++; if (rsp_data !== rx) $display("FAIL rsp_hold got %h want %h", rsp_data, rx); else pass_cnt++;
    last_m = e;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; m_done = 1'b0; m_busy = 1'b0; m_rx_data = '0;
    tick(); tick();
    reset = 1'b0;
    last_m = N - 1; rsp_m = '0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++; if ({gnt, done, err, m_start, m_tx_data, rsp_data} !== '0)
      $display("FAIL reset_outputs gnt %b done %b err %b st %b tx %h rsp %h want all 0", gnt, done, err, m_start, m_tx_data, rsp_data);
    else pass_cnt++;
    // m_done while idle must be ignored
    m_done = 1'b1; m_rx_data = 8'h77;
    tick();
    m_done = 1'b0;
    tick();
    tot_cnt++; if (done !== '0 || rsp_data !== '0) $display("FAIL stray_mdone_idle done %b rsp %h want 0 00", done, rsp_data); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    do_reset();
    req_data = '0; req_data[7:0] = 8'hA5;
    run_txn(4'b0001, 4'b0001, 8'h3C, 10, g);
    req = '0;
  endtask

  task automatic test_all();
    logic [N-1:0] g;
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_data = {$urandom, $urandom} >> 0;
      run_txn(4'b1111, 4'b1111, DW'($urandom), $urandom_range(1, 4), g);
      tot_cnt++; if (g !== (N'(1) << order[i])) $display("FAIL rr_order txn %0d got %b want %b", i, g, N'(1) << order[i]); else pass_cnt++;
    end
    req = '0;
  endtask

  task automatic test_last1();
    logic [N-1:0] g;
    do_reset();
    req_data = 32'h44332211;
    run_txn(4'b0010, 4'b0000, 8'h10, 2, g);   // leaves last = 1
    run_txn(4'b1010, 4'b1010, 8'h20, 3, g);
    tot_cnt++; if (g !== 4'b1000) $display("FAIL after_last1_first got %b want 1000", g); else pass_cnt++;
    run_txn(4'b1010, 4'b0000, 8'h30, 2, g);
    tot_cnt++; if (g !== 4'b0010) $display("FAIL after_last1_second got %b want 0010", g); else pass_cnt++;
  endtask

  task automatic test_drop();
    logic [N-1:0] g;
    do_reset();
    req_data = 32'hDEADBEEF;
    run_txn(4'b0100, 4'b0000, 8'h5A, 5, g);
    tot_cnt++; if (g !== 4'b0100) $display("FAIL drop_gnt got %b want 0100", g); else pass_cnt++;
    g = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      g |= gnt | {3'b0, m_start};
    end
    tot_cnt++; if (g !== '0) $display("FAIL drop_no_regrant got %b want 0", g); else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    logic [N-1:0] seen;
    do_reset();
    req_data = 32'h000000C3;
    req = 4'b0001;
    tick(); tick(); tick();   // START, WAIT, WAIT
    #2 reset = 1'b1;
    #1;
    tot_cnt++; if ({gnt, done, err, m_start, m_tx_data, rsp_data} !== '0)
      $display("FAIL reset_mid_outputs gnt %b done %b err %b st %b tx %h rsp %h want all 0", gnt, done, err, m_start, m_tx_data, rsp_data);
    else pass_cnt++;
    req = '0;
    tick();
    reset = 1'b0;
    last_m = N - 1;
    m_done = 1'b1; m_rx_data = 8'hEE;
    tick();
    m_done = 1'b0;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      seen |= done | gnt;
      tick();
    end
    tot_cnt++; if (seen !== '0 || rsp_data !== '0) $display("FAIL reset_mid_stray seen %b rsp %h want 0 00", seen, rsp_data); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      req_data = {$urandom};
      run_txn(N'($urandom_range(1, 15)), N'($urandom_range(0, 15)),
              DW'($urandom), $urandom_range(1, 6), g);
    end
    req = '0;
  endtask

`ifdef SPI_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_data = 32'h00000011;
    req = 4'b0001;
    tick();            // START
    tick();            // first WAIT cycle
    repeat (15) tick();
    tot_cnt++; if (done !== '0) $display("FAIL tmo_early got %b want 0", done); else pass_cnt++;
    tick();
    tot_cnt++; if (done !== 4'b0001 || err !== 1'b1 || rsp_data !== 8'hFF)
      $display("FAIL tmo_fire done %b err %b rsp %h want 0001 1 ff", done, err, rsp_data);
    else pass_cnt++;
    req = '0;
    tick();
    tot_cnt++; if (err !== 1'b0 || gnt !== '0) $display("FAIL tmo_clear err %b gnt %b want 0 0", err, gnt); else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; req_data = '0;
    m_busy = 1'b0; m_done = 1'b0; m_rx_data = '0;
    test_reset();
    test_single();
    test_all();
    test_last1();
    test_drop();
    test_reset_wait();
    test_random();
`ifdef SPI_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
